// File: rtl/chunked_subtractor_pkg.sv
// Shared types and sizing helpers for the chunked subtractor.
package chunked_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF  = 32;
   localparam int CHUNK_DEF  = 8;
   localparam int NCHUNK_DEF = WIDTH_DEF / CHUNK_DEF;

   function automatic int nchunk_of(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Chunk index needs at least one bit even for a single-chunk build.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunked_subtractor_sub_chunk.sv
// Combinational CHUNK-bit slice computing a + ~b + cin as a chain of full-adder cells.
module chunked_subtractor_sub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o
);

   logic [CHUNK:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      logic x;
      logic y;
      assign x        = a_i[i];
      assign y        = ~b_i[i];
      assign sum_o[i] = x ^ y ^ c[i];
      assign c[i+1]   = (x & y) | (c[i] & (x ^ y));
   end

   assign cout_o = c[CHUNK];

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: diff = a - b, CHUNK bits per cycle, LSB chunk first.
// Optional macro SUB_SATURATE_EN clamps diff to 0 when the subtraction borrows.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one chunk per cycle, carry held in carry_q
// DONE  | result held until out_valid && out_ready
module chunked_subtractor
   import chunked_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
   localparam int IW     = idx_width(NCHUNK);
   localparam int MSB    = WIDTH - 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_param
      $error("chunked_subtractor: WIDTH must be a positive multiple of CHUNK");
   end

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_d;
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic             borrow_q;
   logic             ovf_q;
   logic             out_valid_q;
   logic             in_ready_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] sum;
   logic             cout;

   assign a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
   assign b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];

   chunked_subtractor_sub_chunk #(
      .CHUNK (CHUNK)
   ) u_sub_chunk (
      .a_i    (a_chunk),
      .b_i    (b_chunk),
      .cin_i  (carry_q),
      .sum_o  (sum),
      .cout_o (cout)
   );

   always_comb begin
      diff_d = diff_q;
      diff_d[int'(idx_q)*CHUNK +: CHUNK] = sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         carry_q     <= 1'b1;
         idx_q       <= '0;
         borrow_q    <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  carry_q    <= 1'b1;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               carry_q <= cout;
               idx_q   <= idx_q + IW'(1);
               diff_q  <= diff_d;
               if (idx_q == LAST_IDX) begin
                  // Flags always describe the raw modular result, even when clamped.
                  borrow_q    <= ~cout;
                  ovf_q       <= (a_q[MSB] ^ b_q[MSB]) & (a_q[MSB] ^ diff_d[MSB]);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
`ifdef SUB_SATURATE_EN
                  if (!cout) begin
                     diff_q <= '0;
                  end
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor: directed vectors, stall/reset sequences, random scoreboard.
module tb_chunked_subtractor;

   localparam int W      = 32;
   localparam int N_RAND = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  diff;
   logic          borrow;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chunked_subtractor #(
      .WIDTH (32),
      .CHUNK (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .overflow  (overflow)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference result {overflow, borrow, diff} from plain arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      d  = x - y;
      br = (x < y);
      ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
`ifdef SUB_SATURATE_EN
      if (br) d = '0;
`endif
      return {ov, br, d};
   endfunction

   // Returns number of edges from the accept edge (counted as 1) to out_valid seen high.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_op", in_ready, 1);
      in_valid = 1'b1;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         br;
      logic         ov;
   } vec_t;

   vec_t vecs[8];

   logic [W+1:0] q[$];
   int           rcv = 0;
   bit           mon_done = 0;

   initial begin
      int           lat;
      logic [W-1:0] held;

      vecs[0] = '{32'd10,        32'd3,          32'd7,          1'b0, 1'b0};
      vecs[1] = '{32'd3,         32'd10,         32'hFFFF_FFF9,  1'b1, 1'b0};
      vecs[2] = '{32'h8000_0000, 32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};
      vecs[3] = '{32'h0000_0100, 32'h0000_0001,  32'h0000_00FF,  1'b0, 1'b0};
      vecs[4] = '{32'd0,         32'd0,          32'd0,          1'b0, 1'b0};
      vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b1};
      vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
      vecs[7] = '{32'd0,         32'd1,          32'hFFFF_FFFF,  1'b1, 1'b0};
`ifdef SUB_SATURATE_EN
      vecs[1].d = 32'd0;
      vecs[5].d = 32'd0;
      vecs[7].d = 32'd0;
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      chk("rst_overflow", overflow, 0);

      // Directed vectors with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].a, vecs[i].b, lat);
         chk($sformatf("vec%0d_latency", i), lat, 5);
         chk($sformatf("vec%0d_diff", i), diff, vecs[i].d);
         chk($sformatf("vec%0d_borrow", i), borrow, vecs[i].br);
         chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].ov);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out_valid_drop", i), out_valid, 0);
         chk($sformatf("vec%0d_in_ready_back", i), in_ready, 1);
      end

      // Stall in DONE for 10 cycles with new operands offered
      out_ready = 1'b0;
      send(32'h1234_5678, 32'h1111_1111, lat);
      chk("stall_latency", lat, 5);
      held = 32'h0123_4567;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         a = $urandom;
         b = $urandom;
         @(posedge clk);
         #1;
         chk("stall_out_valid", out_valid, 1);
         chk("stall_diff", diff, held);
         chk("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release_out_valid", out_valid, 0);
      chk("stall_release_in_ready", in_ready, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("stall_no_ghost_result", out_valid, 0);
      chk("stall_idle_in_ready", in_ready, 1);

      // Reset in the middle of RUN (chunk index 2)
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'hDEAD_BEEF;
      b = 32'h0000_0001;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_out_valid", out_valid, 0);
      chk("midrun_rst_diff", diff, 0);
      send(32'd5, 32'd5, lat);
      chk("after_rst_latency", lat, 5);
      chk("after_rst_diff", diff, 0);
      chk("after_rst_borrow", borrow, 0);
      chk("after_rst_overflow", overflow, 0);
      @(posedge clk);
      #1;

      // Random back-to-back ops against the scoreboard
      fork
         begin : driver
            for (int i = 0; i < N_RAND && !mon_done; i++) begin
               int  n;
               bit  ok;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               @(negedge clk);
               #1;
               in_valid = 1'b1;
               a = $urandom;
               b = ($urandom_range(0, 7) == 0) ? a : $urandom;
               n = 0;
               ok = 0;
               while (!ok && n < 200 && !mon_done) begin
                  #2;
                  ok = in_ready;
                  @(negedge clk);
                  #1;
                  n++;
               end
               in_valid = 1'b0;
            end
         end
         begin : ready_toggler
            while (!mon_done) begin
               @(negedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin : monitor
            int           cyc;
            logic [W+1:0] exp;
            cyc = 0;
            while (rcv < N_RAND && cyc < N_RAND * 60) begin
               @(negedge clk);
               #3;
               cyc++;
               if (in_valid && in_ready) q.push_back(model(a, b));
               if (out_valid && out_ready) begin
                  if (q.size() == 0) begin
                     chk("rand_unexpected_result", {overflow, borrow, diff}, 64'h1_0000_0000_0000);
                  end else begin
                     exp = q.pop_front();
                     chk("rand_result", {overflow, borrow, diff}, exp);
                  end
                  rcv++;
               end
            end
            mon_done = 1;
         end
      join

      chk("rand_result_count", rcv, N_RAND);
      chk("rand_pending_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor; computes diff = a - b as a + ~b + 1, CHUNK bits per cycle, LSB chunk first.
Borrow propagates between chunks through a registered carry.
It is the inverse-direction counterpart of the 32-bit ripple-carry adder datapath and sits beside it in the arithmetic unit.
Valid/ready on both sides, so it can be stalled by upstream and downstream logic.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, bits processed per cycle; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a/b valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  a - b modulo 2^WIDTH.
borrow  output  1  1 when a < b (unsigned); equals NOT final carry.
overflow  output  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a).

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at posedge): state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0, chunk index=0, carry register=1. rst mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a and b into internal registers, set carry=1 and index=0, go to RUN.
- RUN: in_ready=0. Each cycle: process chunk[index] = a_chunk + ~b_chunk + carry, write the CHUNK result bits into diff[index*CHUNK +: CHUNK], update carry to the chunk carry-out, increment index.
- Leaving RUN: after the last chunk (index = WIDTH/CHUNK - 1), go to DONE. On that same edge:
  - borrow <= ~carry_out.
  - overflow <= (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]).
  - out_valid <= 1.
- Latency: the result is visible WIDTH/CHUNK+1 clocks after the accept edge (5 for the defaults). Throughput is one operation per WIDTH/CHUNK+2 cycles with out_ready held high.
- DONE: out_valid=1; diff, borrow and overflow are held stable until out_valid&&out_ready. On handshake: out_valid <= 0, go to IDLE.
- in_ready is 0 in RUN and DONE; there is no overlap of operations and no input buffering.
- Outputs are registered only; nothing combinational passes from input to output.
- in_valid while not ready is ignored. a/b may change freely after the accept edge.

Optional Feature:
SUB_SATURATE_EN
- Defined: when the final borrow=1, diff is forced to 0 (unsigned floor) at the DONE transition. borrow and overflow still report the raw condition.
- Undefined: diff is the modular result.

Decomposition:
- Package chunked_subtractor_pkg holds:
  - state enum typedef {IDLE, RUN, DONE};
  - localparam NCHUNK = WIDTH/CHUNK;
  - index width $clog2(NCHUNK) (minimum 1).
- One natural sub-module, sub_chunk: a combinational CHUNK-bit a + ~b + cin producing sum and cout, built from a chain of the existing full-adder cells.
- The FSM, registers and handshake stay in the top module.

Test Plan:
- a=10, b=3, out_ready=1 -> diff=7, borrow=0, overflow=0; out_valid rises exactly 5 clocks after the accept edge.
- a=3, b=10 -> diff=0xFFFFFFF9, borrow=1, overflow=0; with SUB_SATURATE_EN -> diff=0, borrow=1.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, overflow=1. a=0x00000100, b=0x00000001 -> diff=0x000000FF (borrow crosses the chunk boundary).
- Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, diff stable, in_ready=0, new in_valid ignored. Raise out_ready -> one handshake, then IDLE with in_ready=1.
- Assert rst during RUN (index=2) -> next cycle IDLE, out_valid=0, diff=0. A new operation a=5, b=5 -> diff=0, borrow=0.
- Random back-to-back ops (1000 pairs, random in_valid/out_ready gaps) -> every diff/borrow/overflow matches the reference model. No result is lost or duplicated.
